turbo_puncture_packer: RTL and testbench
========================================

// Module: turbo_puncture_packer
// PURPOSE
// - Output stage downstream of the 8-bit turbo encoder. Consumes one (sys, p1, p2) triple per handshake.
// - Applies rate matching: rate 1/3 passes all bits; rate 1/2 punctures p1/p2 alternately.
// - Packs the surviving bits MSB-first into bytes. Buffers them in a small FIFO.
// - Presents bytes on a valid/ready stream with a frame-end marker.
// PARAMETERS
// FIFO_DEPTH   4   byte entries in output FIFO (power of 2, >=2)
// LVL_W        3   width of fifo_level = $clog2(FIFO_DEPTH)+1
// PORTS
// clk         in   1      single clock, rising edge
// rst_n       in   1      asynchronous, active-low reset
// mode        in   1      0 = rate 1/3, 1 = rate 1/2 (sampled on first triple of each frame)
// in_valid    in   1      triple valid
// in_ready    out  1      triple accepted when in_valid & in_ready
// in_sys      in   1      systematic bit
// in_p1       in   1      parity bit, constituent encoder 1
// in_p2       in   1      parity bit, constituent encoder 2 (interleaved)
// in_last     in   1      final triple of frame (tail included)
// out_valid   out  1      byte available
// out_ready   in   1      downstream accepts byte
// out_data    out  8      packed byte, first bit in bit 7
// out_last    out  1      byte is last of frame
// fifo_level  out  LVL_W  bytes currently held in FIFO
// BEHAVIOUR
// - Reset (async, rst_n=0): state=RUN, acc empty, phase=0, FIFO empty.
//   Outputs: out_valid=0, out_data=0, out_last=0, fifo_level=0.
// - in_ready = (state==RUN) & (fifo_level<FIFO_DEPTH). No combinational path from out_ready to in_ready.
// - Per accepted triple, emitted bits in order:
//   - rate 1/3: sys, p1, p2.
//   - rate 1/2: sys, then p1 if phase==0, else p2.
//   - phase toggles on every accepted triple.
// - The frame mode is latched on the first accept after reset or after a frame flush. A mode change mid-frame is ignored.
// - Accumulator is 10 bits. When it holds >=8 bits, the oldest 8 bits are pushed to the FIFO in the same edge and the remainder is kept.
// - A non-last push occurs at most once per cycle.
// - On an accepted triple with in_last=1, state -> FLUSH.
// - FLUSH:
//   - One byte is pushed per cycle when the FIFO is not full: whole bytes first, then the final partial byte zero-padded in its LSBs.
//   - The final pushed byte carries out_last=1.
//   - If the accumulator is exactly 8 bits or 0 bits remain after the push, the previous/only byte carries out_last=1.
//   - Then phase=0, acc empty, state -> RUN.
// - FIFO is first-word-fall-through:
//   - A byte pushed at edge t is visible on out_data/out_valid after edge t.
//   - Latency from the completing triple accept to out_valid = 1 cycle.
// - Pop on out_valid & out_ready. On a simultaneous push and pop, fifo_level is unchanged. A push when full never occurs, because it is gated by in_ready/FLUSH.
// - out_data/out_last are held stable while out_valid=1 and out_ready=0.
// - Reset asserted in any state: buffered bytes are discarded and outputs are forced to their reset values immediately. The next frame starts at phase 0.
// STRUCTURE
// - Package turbo_pkg: MODE_R13=1'b0, MODE_R12=1'b1; state enum {RUN, FLUSH}; TRIPLE_W=3; BYTE_W=8.
// - Sub-module turbo_byte_fifo: sync FIFO, 9-bit entries {last, data}, FWFT, async active-low reset, level output.
// - Top: puncture mux, accumulator/bit counter, RUN/FLUSH FSM.
// TESTING
// - Rate 1/3, triples (1,0,1),(1,1,0),(0,0,1 last), out_ready=1.
//   -> bytes 0xB8 (last=0), then 0x80 (last=1).
// - Rate 1/2, triples (1,0,1),(1,1,0),(1,0,0),(0,1,1 last).
//   -> single byte 0xA9 with last=1; the next frame starts with phase 0.
// - Backpressure: out_ready=0, 40 rate-1/3 triples with last on the 40th.
//   -> in_ready drops when fifo_level=4; after release, exactly 15 bytes arrive in order; last only on the 15th.
// - Mode toggled 0->1 mid-frame.
//   -> the frame stays at rate 1/3 (3 bits/triple); the next frame uses rate 1/2.
// - rst_n pulsed low during FLUSH with 3 bytes queued.
//   -> out_valid=0 and fifo_level=0 immediately; a following 8-bit frame yields exactly one byte with last=1.
// - Random valid/ready throttling with 1000 frames vs reference model.
//   -> bit-exact bytes; no loss, duplication or stall.

Source files
------------

// File: rtl/turbo_puncture_packer_pkg.sv
// Shared definitions for the turbo puncture/packer output stage.
// Holds the rate-mode encodings, the RUN/FLUSH state type, bit widths
// and the {last, data} FIFO entry layout.
package turbo_pkg;

  localparam logic MODE_R13 = 1'b0;
  localparam logic MODE_R12 = 1'b1;

  localparam int TRIPLE_W = 3;
  localparam int BYTE_W   = 8;
  localparam int ACC_W    = 10;
  localparam int CNT_W    = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/turbo_puncture_packer_if.sv
// Stream bundle for turbo_puncture_packer.
// Input side: one (sys, p1, p2) triple per in_valid/in_ready handshake,
// with in_last marking the end of a frame and mode selecting the rate.
// Output side: packed bytes on out_valid/out_ready with out_last, plus
// the current FIFO occupancy on fifo_level.
// master = stream source/sink (testbench or upstream), slave = the packer.
interface turbo_puncture_packer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
  import turbo_pkg::*;

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic              in_sys;
  logic              in_p1;
  logic              in_p2;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output mode, in_valid, in_sys, in_p1, in_p2, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, fifo_level
  );

  modport slave (
    input  mode, in_valid, in_sys, in_p1, in_p2, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, fifo_level
  );

endinterface

// File: rtl/turbo_byte_fifo.sv
// First-word-fall-through synchronous FIFO of {last, data} entries.
// Ports: clk/rst_n (async active-low), push/push_entry write side,
// pop read side (ignored when empty), out_valid/out_entry head of queue
// (forced to zero while empty), level = entries currently held.
// The writer never pushes while full, so no overflow guard is needed.
module turbo_byte_fifo
  import turbo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic             out_valid,
  output entry_t           out_entry,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_pop;

  assign out_valid = (level_q != '0);
  assign do_pop    = pop & out_valid;
  assign level     = level_q;
  assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;

  // Pointer/level update; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/turbo_puncture_packer.sv
// Output stage behind the turbo encoder: punctures each (sys, p1, p2)
// triple according to the frame rate, packs surviving bits MSB-first into
// bytes and queues them in a FWFT FIFO with a frame-end marker.
// Ports: clk, rst_n (async active-low), bus (slave side of
// turbo_puncture_packer_if: triple input stream, byte output stream,
// fifo_level).
module turbo_puncture_packer
  import turbo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  turbo_puncture_packer_if.slave bus
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_ins;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_sum, new_cnt;
  logic                phase_q, phase_d;
  logic                mode_q, mode_d;
  logic                first_q, first_d;
  logic [TRIPLE_W-1:0] new_bits;
  logic                frame_mode, accept, fifo_full, push;
  entry_t              push_entry, head;

  assign fifo_full    = (bus.fifo_level >= LVL_W'(FIFO_DEPTH));
  assign bus.in_ready = (state_q == RUN) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;

  // The rate is taken live from the port only on a frame's first triple.
  assign frame_mode = first_q ? bus.mode : mode_q;

  // Puncture mux: surviving bits left-aligned, unused LSB kept zero.
  always_comb begin
    new_bits = {bus.in_sys, bus.in_p1, bus.in_p2};
    new_cnt  = CNT_W'(3);
    if (frame_mode == MODE_R12) begin
      new_bits = {bus.in_sys, (phase_q ? bus.in_p2 : bus.in_p1), 1'b0};
      new_cnt  = CNT_W'(2);
    end
  end

  // Accumulator keeps the oldest bit at bit ACC_W-1; new bits land just
  // below the valid ones.
  assign acc_ins = acc_q | ({new_bits, {(ACC_W-TRIPLE_W){1'b0}}} >> cnt_q);
  assign cnt_sum = cnt_q + new_cnt;

  // RUN/FLUSH next-state and push generation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    first_d    = first_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      RUN: begin
        if (accept) begin
          mode_d  = frame_mode;
          first_d = 1'b0;
          phase_d = ~phase_q;
          acc_d   = acc_ins;
          cnt_d   = cnt_sum;
          if (cnt_sum >= CNT_W'(BYTE_W)) begin
            push            = 1'b1;
            push_entry.data = acc_ins[ACC_W-1 -: BYTE_W];
            acc_d           = {acc_ins[ACC_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt_d           = cnt_sum - CNT_W'(BYTE_W);
          end
          if (bus.in_last) begin
            // A frame that ends on a byte boundary closes right here.
            if (cnt_sum == CNT_W'(BYTE_W)) begin
              push_entry.last = 1'b1;
              phase_d         = 1'b0;
              first_d         = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (!fifo_full) begin
          push            = 1'b1;
          push_entry.data = acc_q[ACC_W-1 -: BYTE_W];
          push_entry.last = 1'b1;
          acc_d           = '0;
          cnt_d           = '0;
          phase_d         = 1'b0;
          first_d         = 1'b1;
          state_d         = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mode_q  <= MODE_R13;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      first_q <= first_d;
    end
  end

  turbo_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (bus.out_ready),
    .out_valid  (bus.out_valid),
    .out_entry  (head),
    .level      (bus.fifo_level)
  );

  assign bus.out_data = head.data;
  assign bus.out_last = head.last;

endmodule

// File: tb/tb_turbo_puncture_packer.sv
// Directed testbench for turbo_puncture_packer: reset state, rate 1/3 and
// 1/2 packing, phase restart, mid-frame mode change, backpressure, reset
// during flush, and a randomly throttled multi-frame run against a
// bit-queue reference model.
module tb_turbo_puncture_packer;
  import turbo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  turbo_puncture_packer_if #(.FIFO_DEPTH(4), .LVL_W(3)) bus ();

  turbo_puncture_packer #(.FIFO_DEPTH(4), .LVL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  bit         frame_bits [$];
  logic       m_mode  = MODE_R13;
  logic       m_phase = 1'b0;
  logic       m_first = 1'b1;
  logic       throttle     = 1'b0;
  logic       rand_ready   = 1'b0;
  logic       manual_ready = 1'b0;
  logic [7:0] bp_bytes [3] = '{8'h05, 8'h39, 8'h77};

  assign bus.out_ready = throttle ? rand_ready : manual_ready;

  // Random downstream readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rand_ready = 1'($urandom_range(0, 1));
  end

  // Record every byte that the coming rising edge will pop.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_last, bus.out_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: collect surviving bits per frame, pack at frame end.
  task automatic modelTriple(input logic s, input logic p1, input logic p2,
                             input logic last);
    int nbytes;
    if (m_first) begin
      m_mode  = bus.mode;
      m_first = 1'b0;
    end
    frame_bits.push_back(s);
    if (m_mode == MODE_R13) begin
      frame_bits.push_back(p1);
      frame_bits.push_back(p2);
    end else begin
      frame_bits.push_back(m_phase ? p2 : p1);
    end
    m_phase = ~m_phase;
    if (last) begin
      while ((frame_bits.size() % 8) != 0) frame_bits.push_back(1'b0);
      nbytes = frame_bits.size() / 8;
      for (int b = 0; b < nbytes; b++) begin
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = frame_bits[b*8+k];
        exp_q.push_back({(b == nbytes - 1), v});
      end
      frame_bits.delete();
      m_phase = 1'b0;
      m_first = 1'b1;
    end
  endtask

  // Present one triple and return #1 after the edge that accepts it.
  task automatic applyStimulus(input logic s, input logic p1, input logic p2,
                               input logic last);
    int wait_cycles = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sys   = s;
    bus.in_p1    = p1;
    bus.in_p2    = p2;
    bus.in_last  = last;
    while (!done && wait_cycles < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        wait_cycles++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $error("[TB] FAIL accept_timeout: observed no accept within %0d cycles, required accept", wait_cycles);
    end else begin
      modelTriple(s, p1, p2, last);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bus.mode     = MODE_R13;
    bus.in_valid = 1'b0;
    bus.in_sys   = 1'b0;
    bus.in_p1    = 1'b0;
    bus.in_p2    = 1'b0;
    bus.in_last  = 1'b0;

    // Reset values
    #3;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #19 rst_n = 1'b1;
    idle(1);

    // Rate 1/3: 9 bits -> 0xB8, 0x80(last)
    manual_ready = 1'b1;
    got_q.delete();
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("r13_latency_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("r13_latency_data", 32'(bus.out_data), 32'hB8);
    checkOutput("r13_latency_last", 32'(bus.out_last), 32'd0);
    idle(5);
    checkOutput("r13_count", 32'(got_q.size()), 32'd2);
    checkOutput("r13_byte0", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FF), 32'h0B8);
    checkOutput("r13_byte1", 32'((got_q.size() > 1) ? got_q[1] : 9'h1FF), 32'h180);

    // Rate 1/2: 8 bits -> 0xA9(last), then an odd frame, then 0xA9 again
    got_q.delete();
    bus.mode = MODE_R12;
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("r12_latency_data", 32'(bus.out_data), 32'hA9);
    checkOutput("r12_latency_last", 32'(bus.out_last), 32'd1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    idle(5);
    checkOutput("r12_count", 32'(got_q.size()), 32'd3);
    checkOutput("r12_byte0", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FF), 32'h1A9);
    checkOutput("r12_odd_frame", 32'((got_q.size() > 1) ? got_q[1] : 9'h1FF), 32'h1DC);
    checkOutput("r12_phase_restart", 32'((got_q.size() > 2) ? got_q[2] : 9'h1FF), 32'h1A9);

    // Mode change mid-frame is ignored; the next frame takes the new rate
    got_q.delete();
    bus.mode = MODE_R13;
    applyStimulus(1, 0, 1, 0);
    bus.mode = MODE_R12;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    idle(5);
    checkOutput("mode_count", 32'(got_q.size()), 32'd3);
    checkOutput("mode_byte0", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FF), 32'h0B8);
    checkOutput("mode_byte1", 32'((got_q.size() > 1) ? got_q[1] : 9'h1FF), 32'h180);
    checkOutput("mode_next_frame", 32'((got_q.size() > 2) ? got_q[2] : 9'h1FF), 32'h1A9);

    // Backpressure: 40 rate-1/3 triples (i[2:0]) -> 05 39 77 repeated
    got_q.delete();
    bus.mode     = MODE_R13;
    manual_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i[2], i[1], i[0], 0);
      checkOutput("bp_level", 32'(bus.fifo_level), 32'((3 * (i + 1)) / 8));
    end
    checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    idle(3);
    checkOutput("bp_hold_level", 32'(bus.fifo_level), 32'd4);
    checkOutput("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_hold_data", 32'(bus.out_data), 32'h05);
    checkOutput("bp_hold_last", 32'(bus.out_last), 32'd0);
    manual_ready = 1'b1;
    for (int i = 11; i < 40; i++) applyStimulus(i[2], i[1], i[0], (i == 39));
    idle(12);
    checkOutput("bp_count", 32'(got_q.size()), 32'd15);
    for (int k = 0; k < 15; k++)
      checkOutput($sformatf("bp_byte%0d", k),
                  32'((got_q.size() > k) ? got_q[k] : 9'h1FF),
                  32'({(k == 14), bp_bytes[k % 3]}));

    // Reset during FLUSH with 3 bytes queued
    got_q.delete();
    manual_ready = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(i[2], i[1], i[0], (i == 8));
    checkOutput("flush_level_before_rst", 32'(bus.fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("flush_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_rst_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("flush_rst_data", 32'(bus.out_data), 32'd0);
    checkOutput("flush_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    frame_bits.delete();
    m_phase = 1'b0;
    m_first = 1'b1;
    idle(1);
    manual_ready = 1'b1;
    bus.mode     = MODE_R12;
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    idle(6);
    checkOutput("post_rst_count", 32'(got_q.size()), 32'd1);
    checkOutput("post_rst_byte", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FF), 32'h1A9);

    // Randomly throttled frames against the reference model
    got_q.delete();
    exp_q.delete();
    throttle = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len      = $urandom_range(1, 12);
      bus.mode = 1'($urandom_range(0, 1));
      for (int t = 0; t < len; t++) begin
        if (t != 0) bus.mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) idle(1);
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), (t == len - 1));
      end
    end
    w = 0;
    while (got_q.size() < exp_q.size() && w < 2000) begin
      @(posedge clk);
      w++;
    end
    idle(5);
    checkOutput("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      checkOutput($sformatf("rand_byte%0d", k),
                  32'((got_q.size() > k) ? got_q[k] : 9'h1FF), 32'(exp_q[k]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
